serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n_in  input  1  reset, asynchronous and active-low.
REQ-004 start_in  input  1  request to begin an addition; accepted only while ready_out=1.
REQ-005 a_in  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 b_in  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 c_in  input  1  carry-in, sampled on the accepting edge.
REQ-008 ready_out  output  1  high when a start_in will be accepted.
REQ-009 busy_out  output  1  high while bits are being processed.
REQ-010 done_out  output  1  one-cycle pulse when the result becomes valid.
REQ-011 sum_out  output  WIDTH  result; valid from done_out until the next accepted start.
REQ-012 c_out  output  1  final carry-out; valid with sum_out.
REQ-013 overflow_out  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB); valid with sum_out.

Function
REQ-014 Datapath SHALL be exactly one instance of the team's FullAdder cell, one carry flip-flop, operand shift registers, and a result shift register; no WIDTH-bit adder.
REQ-015 FSM states: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: ready_out=1, busy_out=0, done_out=0; start_in=1 -> load A, B, carry<=c_in, bit counter<=0, go to RUN.
REQ-017 RUN: ready_out=0, busy_out=1; each edge adds LSB of A, LSB of B and carry, shifts A and B right by one, shifts the sum bit into the result MSB (result shifts right), updates carry, increments counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, record carry-in of that bit for overflow, latch final carry into c_out, go to DONE.
REQ-019 DONE: done_out=1 for exactly one cycle, ready_out=1, busy_out=0; next edge -> IDLE, or RUN if start_in=1 (back-to-back accept).
REQ-020 Latency: start accepted at edge 0 -> done_out high in the cycle following edge WIDTH; throughput one addition per WIDTH+1 cycles.
REQ-021 start_in during RUN SHALL be ignored; no queuing, operands and result unaffected.
REQ-022 sum_out, c_out, overflow_out SHALL hold their values through IDLE until the next accepted start; during RUN their values are don't-care for the consumer but SHALL NOT be X.
REQ-023 Arithmetic: {c_out, sum_out} = a_in + b_in + c_in, modulo 2^(WIDTH+1); no saturation.
REQ-024 Counter width SHALL be ceil(log2(WIDTH)) bits minimum; no wrap past WIDTH-1 in RUN.

Reset
REQ-025 reset_n_in=0 SHALL immediately force IDLE, independent of clk_in.
REQ-026 Reset values: ready_out=1, busy_out=0, done_out=0, sum_out=0, c_out=0, overflow_out=0, carry=0, counter=0.
REQ-027 Reset during RUN SHALL abandon the operation; no done_out pulse for it.
REQ-028 start_in on the first edge after reset_n_in rises SHALL be accepted.

Verification
REQ-029 WIDTH=16: A=0x0001, B=0x0001, c_in=0 -> after 17 edges done_out=1, sum_out=0x0002, c_out=0, overflow_out=0.
REQ-030 A=0xFFFF, B=0x0001, c_in=0 -> sum_out=0x0000, c_out=1, overflow_out=0; A=0x7FFF, B=0x0001 -> sum_out=0x8000, c_out=0, overflow_out=1.
REQ-031 A=0x1234, B=0x4321, c_in=1 -> sum_out=0x5556, c_out=0; start_in held high with new operands throughout RUN -> ignored, result unchanged.
REQ-032 start_in asserted in the DONE cycle with A=0x00FF, B=0x0F00 -> accepted, busy_out=1 next cycle, second done_out 17 cycles after the first with sum_out=0x0FFF.
REQ-033 reset_n_in pulsed low at RUN bit 8 -> outputs at reset values asynchronously, no done_out; subsequent start completes correctly.
REQ-034 Random compare of 1000 triples against {c_out, sum_out}=a+b+c_in, plus check that done_out is never high for two consecutive cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Also reports final carry and two's-complement overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             overflow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, c_out_q, ovf_q;
    logic             load, last;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        ready_out = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (start_in) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_out = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                ready_out = 1'b1;
                done_out  = 1'b1;
                // back-to-back accept straight from DONE
                if (start_in) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= {fa_s, res_q[WIDTH-1:1]};
            carry_q <= fa_co;
            if (last) begin
                c_out_q <= fa_co;
                // carry into MSB vs carry out of MSB
                ovf_q   <= carry_q ^ fa_co;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    assign sum_out      = res_q;
    assign c_out        = c_out_q;
    assign overflow_out = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus
// random operands checked against plain integer addition.
module tb_serial_adder;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         ci = 1'b0;
    logic         ready, busy, done, c_o, ovf;
    logic [W-1:0] sum;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_in       (clk),
        .reset_n_in   (rst_n),
        .start_in     (start),
        .a_in         (a),
        .b_in         (b),
        .c_in         (ci),
        .ready_out    (ready),
        .busy_out     (busy),
        .done_out     (done),
        .sum_out      (sum),
        .c_out        (c_o),
        .overflow_out (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                   logic c);
        exp_t e;
        logic [W:0] full;
        full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_twice", {63'b0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", {48'b0, sum}, {48'b0, e.sum});
                    check("cout", {63'b0, c_o}, {63'b0, e.c});
                    check("ovf", {63'b0, ovf}, {63'b0, e.ovf});
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_op(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {63'b0, ready}, 64'd1);
        a = x;
        b = y;
        ci = c;
        start = 1'b1;
        @(posedge clk);
        last_exp = model(x, y, c);
        exp_q.push_back(last_exp);
        #1;
        start = 1'b0;
    endtask

    // Returns edges from acceptance until done is visible; -1 on timeout.
    task automatic wait_done(bit hold, output int lat);
        lat = -1;
        for (int n = 1; n <= W + 8; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                start = 1'b0;
                lat = n;
                break;
            end
            if (hold) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                ci = 1'($urandom);
            end
        end
    endtask

    task automatic op(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int lat;
        start_op(x, y, c);
        wait_done(1'b0, lat);
        check("latency", 64'(lat), 64'(W));
    endtask

    initial begin
        int lat;
        #3;
        check("rst_ready", {63'b0, ready}, 64'd1);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_sum", {48'b0, sum}, 64'd0);
        check("rst_cout", {63'b0, c_o}, 64'd0);
        check("rst_ovf", {63'b0, ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(16'h0001, 16'h0001, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0);

        // result holds through idle
        repeat (5) @(negedge clk);
        check("hold_sum", {48'b0, sum}, {48'b0, last_exp.sum});
        check("hold_ovf", {63'b0, ovf}, {63'b0, last_exp.ovf});
        check("idle_ready", {63'b0, ready}, 64'd1);

        // start held high with changing operands during RUN
        start_op(16'h1234, 16'h4321, 1'b1);
        #2;
        check("run_ready", {63'b0, ready}, 64'd0);
        check("run_busy", {63'b0, busy}, 64'd1);
        wait_done(1'b1, lat);
        check("latency_hold", 64'(lat), 64'(W));
        check("sum_1234", {48'b0, sum}, 64'h5556);

        // back-to-back accept from DONE
        start_op(16'h0000, 16'h0000, 1'b1);
        wait_done(1'b0, lat);
        start_op(16'h00FF, 16'h0F00, 1'b0);
        check("b2b_busy", {63'b0, busy}, 64'd1);
        wait_done(1'b0, lat);
        check("b2b_gap", 64'(lat), 64'(W));
        check("sum_0fff", {48'b0, sum}, 64'h0FFF);

        // reset mid-operation
        repeat (3) @(negedge clk);
        start_op(16'hABCD, 16'h1111, 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("arst_ready", {63'b0, ready}, 64'd1);
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_done", {63'b0, done}, 64'd0);
        check("arst_sum", {48'b0, sum}, 64'd0);
        check("arst_cout", {63'b0, c_o}, 64'd0);
        check("arst_ovf", {63'b0, ovf}, 64'd0);
        repeat (W + 4) @(negedge clk);
        check("arst_no_done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;
        start_op(16'h8000, 16'h8000, 1'b1);
        check("post_rst_busy", {63'b0, busy}, 64'd1);
        wait_done(1'b0, lat);
        check("post_rst_lat", 64'(lat), 64'(W));

        for (int i = 0; i < 1000; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0)
                repeat ($urandom_range(3)) @(negedge clk);
        end

        repeat (W + 4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
